// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, colour constants and game_data encoding.
// Pure definitions with no latency or backpressure.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        GD_BACKGROUND = 2'd0,
        GD_BODY       = 2'd1,
        GD_HEAD       = 2'd2,
        GD_FRUIT      = 2'd3
    } game_data_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_BORDER = '{r: 4'h4, g: 4'h4, b: 4'h4};
    localparam rgb_t COL_BODY   = '{r: 4'h0, g: 4'hC, b: 4'h0};
    localparam rgb_t COL_HEAD   = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t COL_FRUIT  = '{r: 4'hF, g: 4'h0, b: 4'h0};

    // Blanked pixels are black whatever the graphic block is presenting.
    function automatic rgb_t colour_of(input logic vis, input logic en, input logic [1:0] gd);
        rgb_t c;
        c = '0;
        if (vis) begin
            if (!en) begin
                c = COL_BORDER;
            end else begin
                case (game_data_e'(gd))
                    GD_BODY:  c = COL_BODY;
                    GD_HEAD:  c = COL_HEAD;
                    GD_FRUIT: c = COL_FRUIT;
                    default:  c = '0;
                endcase
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Bundle between the sync generator (master) and the graphic block / display pins (slave).
// Wires only; no latency, no backpressure.
interface vga_sync_gen_if #(
    parameter int PIXEL_DISPLAY_BIT = 9
) ();
    logic [PIXEL_DISPLAY_BIT:0] X;
    logic [PIXEL_DISPLAY_BIT:0] Y;
    logic                       game_enable;
    logic [1:0]                 game_data;
    logic                       hsync;
    logic                       vsync;
    logic                       video_on;
    logic [3:0]                 vga_r;
    logic [3:0]                 vga_g;
    logic [3:0]                 vga_b;
    logic                       frame_tick;

    modport master (
        output X, Y, hsync, vsync, video_on, vga_r, vga_g, vga_b, frame_tick,
        input  game_enable, game_data
    );

    modport slave (
        input  X, Y, hsync, vsync, video_on, vga_r, vga_g, vga_b, frame_tick,
        output game_enable, game_data
    );
endinterface

// File: rtl/vga_pipe_delay.sv
// Fixed-depth register chain with a per-stage reset value; out_dat lags in_dat by DEPTH cycles.
// pre_dat is the stage before the output (in_dat when DEPTH is 1); no backpressure.
module vga_pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_dat,
    output logic [WIDTH-1:0] out_dat,
    output logic [WIDTH-1:0] pre_dat
);
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock_25) begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= reset ? RST_VAL : stage_d[i];
        end
    end

    assign out_dat = stage_q[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_pre_in
            assign pre_dat = in_dat;
        end else begin : g_pre_chain
            assign pre_dat = stage_q[DEPTH-2];
        end
    endgenerate
endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 pixel/line counters; sync, video_on and colour lag X/Y by PIPE_DELAY (>= 1) cycles.
// Free-running with no backpressure; game_enable/game_data are expected PIPE_DELAY-1 cycles after X/Y.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int PIPE_DELAY        = 2
) (
    input  logic           clock_25,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int CW = PIXEL_DISPLAY_BIT + 1;

    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    // Chain bit order is {visible, hsync, vsync}; idle is blanked with both syncs high.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          frame_tick_q, frame_tick_d;
    rgb_t          colour_q, colour_d;
    logic          x_wrap;
    logic [2:0]    sync_raw;
    logic [2:0]    sync_pre;
    logic [2:0]    sync_out;

    always_comb begin
        x_wrap = (x_q >= X_LAST);
        x_d    = x_wrap ? '0 : x_q + ONE;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = (y_q >= Y_LAST) ? '0 : y_q + ONE;
        end
        frame_tick_d = (x_d == '0) && (y_d == '0);

        sync_raw[2] = (x_q < H_VIS) && (y_q < V_VIS);
        sync_raw[1] = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        sync_raw[0] = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));

        // The stage before the output carries the visible flag for the pixel whose
        // game_data is arriving now, so the colour lands in step with video_on.
        colour_d = colour_of(sync_pre[2], vga.game_enable, vga.game_data);
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_tick_q <= 1'b0;
            colour_q     <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            frame_tick_q <= frame_tick_d;
            colour_q     <= colour_d;
        end
    end

    vga_pipe_delay #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clock_25 (clock_25),
        .reset    (reset),
        .in_dat   (sync_raw),
        .out_dat  (sync_out),
        .pre_dat  (sync_pre)
    );

    assign vga.X          = x_q;
    assign vga.Y          = y_q;
    assign vga.video_on   = sync_out[2];
    assign vga.hsync      = sync_out[1];
    assign vga.vsync      = sync_out[0];
    assign vga.vga_r      = colour_q.r;
    assign vga.vga_g      = colour_q.g;
    assign vga.vga_b      = colour_q.b;
    assign vga.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: reset, line timing, colour mapping, blanking, mid-frame reset, full frame.
module tb_vga_sync_gen;
    localparam int PD = 2;

    logic clock_25 = 1'b0;
    logic reset;
    int   checks;
    int   errors;

    vga_sync_gen_if #(.PIXEL_DISPLAY_BIT(9)) vga ();

    vga_sync_gen #(
        .PIXEL_DISPLAY_BIT (9),
        .PIPE_DELAY        (PD)
    ) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .vga      (vga)
    );

    always #20 clock_25 = ~clock_25;

    task automatic step();
        @(posedge clock_25);
        #1;
    endtask

    task automatic run_to(input logic [9:0] tx, input logic [9:0] ty, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 500000; i++) begin
            if (vga.X === tx && vga.Y === ty) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_reach: got X=%0d Y=%0d required X=%0d Y=%0d", tag, vga.X, vga.Y, tx, ty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (vga.X !== 10'd0) begin errors++; $display("FAIL rst_x: got %0d required 0", vga.X); end
        checks++; if (vga.Y !== 10'd0) begin errors++; $display("FAIL rst_y: got %0d required 0", vga.Y); end
        checks++; if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1) begin errors++; $display("FAIL rst_sync: got hs=%b vs=%b required 1 1", vga.hsync, vga.vsync); end
        checks++; if (vga.video_on !== 1'b0 || vga.frame_tick !== 1'b0) begin errors++; $display("FAIL rst_flags: got video_on=%b tick=%b required 0 0", vga.video_on, vga.frame_tick); end
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h000) begin errors++; $display("FAIL rst_colour: got %h required 000", {vga.vga_r, vga.vga_g, vga.vga_b}); end
        reset = 1'b0;
        step();
        checks++; if (vga.X !== 10'd1 || vga.Y !== 10'd0) begin errors++; $display("FAIL rel_xy: got X=%0d Y=%0d required 1 0", vga.X, vga.Y); end
        for (int k = 1; k <= PD; k++) begin
            if (k > 1) step();
            checks++;
            if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1) begin
                errors++; $display("FAIL rel_sync_%0d: got hs=%b vs=%b required 1 1", k, vga.hsync, vga.vsync);
            end
        end
    endtask

    task automatic test_line();
        logic [9:0] px, py;
        int wrap_c, wrap_x, wrap_y, wrap_py, x656, hs_first, hs_low;
        wrap_c = -1; wrap_x = -1; wrap_y = -1; wrap_py = -1;
        x656 = -1; hs_first = -1; hs_low = 0;
        px = vga.X; py = vga.Y;
        for (int c = 1; c <= 810; c++) begin
            step();
            if (vga.X === 10'd656 && x656 < 0) x656 = c;
            if (vga.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (px === 10'd799 && wrap_c < 0) begin
                wrap_c = c; wrap_x = int'(vga.X); wrap_y = int'(vga.Y); wrap_py = int'(py);
            end
            px = vga.X; py = vga.Y;
        end
        checks++; if (wrap_c !== 800 - PD) begin errors++; $display("FAIL line_wrap_cycle: got %0d required %0d", wrap_c, 800 - PD); end
        checks++; if (wrap_x !== 0) begin errors++; $display("FAIL line_wrap_x: got %0d required 0", wrap_x); end
        checks++; if (wrap_py !== 0 || wrap_y !== 1) begin errors++; $display("FAIL line_wrap_y: got %0d->%0d required 0->1", wrap_py, wrap_y); end
        checks++; if (hs_first !== x656 + PD || x656 !== 656 - PD) begin errors++; $display("FAIL hs_start: got %0d (X=656 at %0d) required %0d", hs_first, x656, 656); end
        checks++; if (hs_low !== 96) begin errors++; $display("FAIL hs_width: got %0d required 96", hs_low); end
    endtask

    task automatic test_colour();
        vga.game_enable = 1'b1;
        vga.game_data   = 2'd0;
        run_to(10'd100, 10'd100, "colour");
        repeat (PD - 1) step();
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h000 || vga.video_on !== 1'b1) begin errors++; $display("FAIL col_bg: got %h von=%b required 000 1", {vga.vga_r, vga.vga_g, vga.vga_b}, vga.video_on); end
        vga.game_data = 2'd3;
        step();
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'hF00 || vga.video_on !== 1'b1) begin errors++; $display("FAIL col_fruit: got %h von=%b required F00 1", {vga.vga_r, vga.vga_g, vga.vga_b}, vga.video_on); end
        vga.game_data = 2'd2;
        step();
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h0F0) begin errors++; $display("FAIL col_head: got %h required 0F0", {vga.vga_r, vga.vga_g, vga.vga_b}); end
        vga.game_enable = 1'b0;
        step();
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h444) begin errors++; $display("FAIL col_border: got %h required 444", {vga.vga_r, vga.vga_g, vga.vga_b}); end
        vga.game_enable = 1'b1;
        vga.game_data   = 2'd1;
        step();
        checks++; if ({vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h0C0) begin errors++; $display("FAIL col_body: got %h required 0C0", {vga.vga_r, vga.vga_g, vga.vga_b}); end
    endtask

    task automatic test_blank();
        vga.game_enable = 1'b1;
        vga.game_data   = 2'd3;
        run_to(10'd639, 10'd100, "edge");
        repeat (PD) step();
        checks++; if (vga.video_on !== 1'b1 || {vga.vga_r, vga.vga_g, vga.vga_b} !== 12'hF00) begin errors++; $display("FAIL last_visible: got von=%b col=%h required 1 F00", vga.video_on, {vga.vga_r, vga.vga_g, vga.vga_b}); end
        step();
        checks++; if (vga.video_on !== 1'b0 || {vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h000) begin errors++; $display("FAIL first_blank: got von=%b col=%h required 0 000", vga.video_on, {vga.vga_r, vga.vga_g, vga.vga_b}); end
        run_to(10'd700, 10'd100, "blank");
        repeat (PD) step();
        checks++; if (vga.video_on !== 1'b0 || {vga.vga_r, vga.vga_g, vga.vga_b} !== 12'h000) begin errors++; $display("FAIL blank_700: got von=%b col=%h required 0 000", vga.video_on, {vga.vga_r, vga.vga_g, vga.vga_b}); end
        checks++; if (vga.hsync !== 1'b0) begin errors++; $display("FAIL hs_700: got %b required 0", vga.hsync); end
        vga.game_enable = 1'b0;
        vga.game_data   = 2'd0;
    endtask

    task automatic test_mid_reset();
        run_to(10'd400, 10'd300, "midrst");
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (vga.X !== 10'd0 || vga.Y !== 10'd0) begin errors++; $display("FAIL midrst_xy: got X=%0d Y=%0d required 0 0", vga.X, vga.Y); end
        checks++; if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1 || vga.frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_sync: got hs=%b vs=%b tick=%b required 1 1 0", vga.hsync, vga.vsync, vga.frame_tick); end
        step();
        checks++; if (vga.X !== 10'd1 || vga.Y !== 10'd0) begin errors++; $display("FAIL midrst_resume1: got X=%0d Y=%0d required 1 0", vga.X, vga.Y); end
        step();
        checks++; if (vga.X !== 10'd2 || vga.Y !== 10'd0) begin errors++; $display("FAIL midrst_resume2: got X=%0d Y=%0d required 2 0", vga.X, vga.Y); end
    endtask

    task automatic test_frame();
        int vs_low, ticks, tick_at, tick_bad, ymax, xmax;
        vs_low = 0; ticks = 0; tick_at = -1; tick_bad = 0; ymax = 0; xmax = 0;
        for (int c = 1; c <= 420000; c++) begin
            step();
            if (vga.vsync === 1'b0) vs_low++;
            if (vga.frame_tick === 1'b1) begin
                ticks++;
                tick_at = c;
                if (vga.X !== 10'd0 || vga.Y !== 10'd0) tick_bad++;
            end
            if (int'(vga.Y) > ymax) ymax = int'(vga.Y);
            if (int'(vga.X) > xmax) xmax = int'(vga.X);
        end
        checks++; if (vs_low !== 1600) begin errors++; $display("FAIL vs_width: got %0d required 1600", vs_low); end
        checks++; if (ticks !== 1) begin errors++; $display("FAIL tick_count: got %0d required 1", ticks); end
        checks++; if (tick_at !== 420000 - 2) begin errors++; $display("FAIL tick_pos: got %0d required %0d", tick_at, 420000 - 2); end
        checks++; if (tick_bad !== 0) begin errors++; $display("FAIL tick_xy: got %0d off-origin ticks required 0", tick_bad); end
        checks++; if (ymax !== 524) begin errors++; $display("FAIL y_max: got %0d required 524", ymax); end
        checks++; if (xmax !== 799) begin errors++; $display("FAIL x_max: got %0d required 799", xmax); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        vga.game_enable = 1'b0;
        vga.game_data   = 2'd0;
        test_reset();
        test_line();
        test_colour();
        test_blank();
        test_mid_reset();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter PIXEL_DISPLAY_BIT, default 9; MSB index of X and Y.
REQ-002 Parameter PIPE_DELAY, default 2; clock_25 cycles from X/Y to the matching game_data pixel at the colour output.
REQ-003 clock_25  input  1  pixel clock (25 MHz); all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 X  output  PIXEL_DISPLAY_BIT+1  current horizontal pixel counter, 0..799.
REQ-006 Y  output  PIXEL_DISPLAY_BIT+1  current vertical line counter, 0..524.
REQ-007 game_enable  input  1  graphic block: pixel lies in the game field; valid PIPE_DELAY-1 cycles after X/Y.
REQ-008 game_data  input  2  graphic block: pixel class; 0 = background, 1 = snake body, 2 = snake head, 3 = fruit.
REQ-009 hsync  output  1  horizontal sync, active-low, aligned to colour output.
REQ-010 vsync  output  1  vertical sync, active-low, aligned to colour output.
REQ-011 video_on  output  1  high while the aligned pixel is visible.
REQ-012 vga_r, vga_g, vga_b  output  4 each  pixel colour; 0 whenever video_on is low.
REQ-013 frame_tick  output  1  one-cycle pulse at the start of each frame.

Function
REQ-014 Horizontal counter X increments every cycle and wraps from 799 to 0.
REQ-015 Vertical counter Y increments only when X wraps 799 to 0, and wraps from 524 to 0 on that same cycle.
REQ-016 Raw visible flag = (X < 640) and (Y < 480).
REQ-017 Raw hsync low for X in 656..751 inclusive; high otherwise.
REQ-018 Raw vsync low for Y in 490..491 inclusive; high otherwise.
REQ-019 Raw visible, hsync and vsync pass through a PIPE_DELAY-stage register chain before they drive video_on, hsync and vsync.
REQ-020 Colour register, loaded every cycle from the registered game_enable/game_data and the delayed visible flag:
- not visible -> 0/0/0
- visible, game_enable = 0 -> border 4/4/4
- game_data 0 -> 0/0/0
- game_data 1 -> 0/C/0
- game_data 2 -> 0/F/0
- game_data 3 -> F/0/0
REQ-021 frame_tick high for exactly one cycle, the cycle in which X = 0 and Y = 0 are presented.
REQ-022 Counter arithmetic is unsigned at full port width; no value outside the ranges in REQ-005 and REQ-006 is ever driven.
REQ-023 Inputs arriving while the delayed visible flag is low are ignored; the colour output is forced to 0.

Reset
REQ-024 While reset is high at a clock edge, the following are loaded:
- X = 0, Y = 0
- every delay-chain stage: visible = 0, hsync = 1, vsync = 1
- colour = 0, frame_tick = 0
REQ-025 A reset asserted mid-line or mid-frame takes effect at the next edge; there is no partial-line completion.
REQ-026 The first edge after reset deasserts gives X = 1, Y = 0.
REQ-027 Outputs reach steady-state alignment PIPE_DELAY cycles after reset release.

Structure
REQ-028 Shared package vga_pkg holds:
- constants H_VISIBLE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48, H_TOTAL = 800
- constants V_VISIBLE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33, V_TOTAL = 525
- the four colour constants and the game_data encoding
REQ-029 One sub-module, vga_pipe_delay, is parameterised by width and depth; it is used for the sync/visible alignment chain.

Verification
REQ-030 Reset for 3 cycles, release -> X = 1, Y = 0 after first edge; hsync and vsync stay high for PIPE_DELAY cycles.
REQ-031 Run one full line -> X goes 799 then 0 and Y goes 0 then 1 on the same edge; hsync is low for exactly 96 cycles, starting PIPE_DELAY cycles after X = 656.
REQ-032 Run a full frame (420000 cycles) ->
- vsync low for exactly 1600 cycles (lines 490-491)
- frame_tick pulses exactly once per 420000 cycles
- Y never exceeds 524
REQ-033 Colour mapping, X = 100 and Y = 100, game_enable = 1:
- game_data = 3 -> vga_r/g/b = F/0/0, PIPE_DELAY cycles later
- game_data = 2 -> 0/F/0
- game_enable = 0 -> 4/4/4
REQ-034 Blanking: X = 700 with game_data = 3 -> colour 0 and video_on = 0.
REQ-035 Mid-frame reset: assert reset at X = 400, Y = 300 for 1 cycle -> next X = 0, Y = 0, hsync = 1; the counter then resumes the normal sequence.
